// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side bundle of the set-associative instruction cache.
// slave is the cache view; master is the datapath/memory view.
interface icache_assoc_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pcRST;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, pcRST, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, pcRST, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative icache: multi-word block fill, round-robin victim, flush, abort.
// Define ICACHE_ASSOC_STATS_EN to build the hit/miss counters.
module icache_assoc #(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2,
    parameter int CPUID    = 0
) (
    input  logic          CLK,
    input  logic          RST,
    icache_assoc_if.slave bus
);
    localparam int OB = $clog2(BLKWORDS);
    localparam int IB = $clog2(SETS);
    localparam int TW = 30 - IB - OB;
    localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW = (OB > 0) ? OB : 1;
    localparam logic [CW-1:0] LastWord = CW'(BLKWORDS - 1);

    if (CPUID < 0 || WAYS > 4 || SETS < 2) begin : gBadParams
    end

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;
    state_t state, nextState;

    logic          validArr  [SETS][WAYS];
    logic [TW-1:0] tagArr    [SETS][WAYS];
    logic [31:0]   dataArr   [SETS][WAYS][BLKWORDS];
    logic [WB-1:0] victimArr [SETS];
    logic [31:0]   fillBuf   [BLKWORDS];

    logic [TW-1:0] fillTag, curTag;
    logic [IB-1:0] fillIdx, curIdx;
    logic [CW-1:0] wc, curWord;
    logic [WB-1:0] hitWay, invWay, victimWay;
    logic          lookupHit, lookupReq, hit, startFill, invFound;
    logic          unusedAddr;

    assign curTag     = bus.imemaddr[31:IB+OB+2];
    assign curIdx     = bus.imemaddr[IB+OB+1:OB+2];
    assign unusedAddr = ^bus.imemaddr[1:0];

    if (OB > 0) begin : gWord
        assign curWord = bus.imemaddr[OB+1:2];
    end else begin : gNoWord
        assign curWord = '0;
    end

    always_comb begin
        lookupHit = 1'b0;
        hitWay    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (validArr[curIdx][w] && tagArr[curIdx][w] == curTag) begin
                lookupHit = 1'b1;
                hitWay    = WB'(w);
            end
        end
    end

    assign lookupReq    = bus.imemREN && !bus.pcRST && !bus.iflush;
    assign hit          = lookupReq && state == IDLE && lookupHit;
    assign startFill    = lookupReq && state == IDLE && !lookupHit;
    assign bus.ihit     = hit;
    assign bus.imemload = hit ? dataArr[curIdx][hitWay][curWord] : 32'h0;

    // Prefer the lowest free way; only fall back on the round-robin pointer.
    always_comb begin
        invFound = 1'b0;
        invWay   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validArr[fillIdx][w]) begin
                invFound = 1'b1;
                invWay   = WB'(w);
            end
        end
        victimWay = invFound ? invWay : victimArr[fillIdx];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (startFill) nextState = FILL;
            FILL: begin
                if (bus.iflush || bus.pcRST)
                    nextState = IDLE;
                else if (!bus.iwait && wc == LastWord)
                    nextState = COMMIT;
            end
            COMMIT:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.iREN  = 1'b0;
        bus.iaddr = 32'h0;
        if (state == FILL) begin
            bus.iREN  = 1'b1;
            bus.iaddr = {fillTag, fillIdx, {(OB+2){1'b0}}}
                      | ({{(32-CW){1'b0}}, wc} << 2);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                victimArr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    validArr[s][w] <= 1'b0;
                    tagArr[s][w]   <= '0;
                    for (int b = 0; b < BLKWORDS; b++)
                        dataArr[s][w][b] <= 32'h0;
                end
            end
            for (int b = 0; b < BLKWORDS; b++)
                fillBuf[b] <= 32'h0;
            fillTag <= '0;
            fillIdx <= '0;
            wc      <= '0;
        end else begin
            if (startFill) begin
                fillTag <= curTag;
                fillIdx <= curIdx;
                wc      <= '0;
            end
            if (state == FILL && !bus.iwait && !bus.pcRST && !bus.iflush) begin
                fillBuf[wc] <= bus.iload;
                if (wc != LastWord) wc <= wc + 1'b1;
            end
            if (state == COMMIT && !bus.iflush) begin
                validArr[fillIdx][victimWay] <= 1'b1;
                tagArr[fillIdx][victimWay]   <= fillTag;
                for (int b = 0; b < BLKWORDS; b++)
                    dataArr[fillIdx][victimWay][b] <= fillBuf[b];
                if (WAYS > 1 && !invFound)
                    victimArr[fillIdx] <= victimWay + 1'b1;
            end
            // Flush is last so it overrides a same-cycle install.
            if (bus.iflush) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        validArr[s][w] <= 1'b0;
            end
        end
    end

`ifdef ICACHE_ASSOC_STATS_EN
    logic [31:0] hitCnt, missCnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hitCnt  <= 32'h0;
            missCnt <= 32'h0;
        end else if (bus.iflush) begin
            hitCnt  <= 32'h0;
            missCnt <= 32'h0;
        end else begin
            if (hit && hitCnt != 32'hFFFF_FFFF)
                hitCnt <= hitCnt + 32'h1;
            if (startFill && missCnt != 32'hFFFF_FFFF)
                missCnt <= missCnt + 32'h1;
        end
    end

    assign bus.hit_count  = hitCnt;
    assign bus.miss_count = missCnt;
`else
    assign bus.hit_count  = 32'h0;
    assign bus.miss_count = 32'h0;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: fills, replacement, stall, abort, flush, reset.
// Memory returns iaddr + 0x60 as the data for every word.
module tb_icache_assoc;
`ifdef ICACHE_ASSOC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int BLK = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   expHits = 0;
    int   expMiss = 0;

    icache_assoc_if ifc();

    icache_assoc #(.SETS(8), .WAYS(2), .BLKWORDS(BLK), .CPUID(0)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    assign ifc.iload = ifc.iaddr + 32'h60;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkCounts(input string tag);
        chk({tag, "_hits"}, ifc.hit_count, STATS ? 32'(expHits) : 32'h0);
        chk({tag, "_miss"}, ifc.miss_count, STATS ? 32'(expMiss) : 32'h0);
    endtask

    // Full fetch: a hit is consumed in one cycle, a miss is filled and re-looked-up.
    task automatic fetch(input logic [31:0] addr, input bit expHit);
        logic [31:0] base;
        base = addr & ~32'(BLK * 4 - 1);
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = addr;
        #1;
        chk("lookup_hit", {31'h0, ifc.ihit}, {31'h0, expHit});
        chk("lookup_load", ifc.imemload, expHit ? addr + 32'h60 : 32'h0);
        step();
        if (expHit) begin
            expHits++;
        end else begin
            expMiss++;
            for (int i = 0; i < BLK; i++) begin
                chk("fill_iren", {31'h0, ifc.iREN}, 32'h1);
                chk("fill_iaddr", ifc.iaddr, base + 32'(4 * i));
                step();
            end
            chk("commit_iren", {31'h0, ifc.iREN}, 32'h0);
            chk("commit_iaddr", ifc.iaddr, 32'h0);
            step();
            chk("refill_hit", {31'h0, ifc.ihit}, 32'h1);
            chk("refill_load", ifc.imemload, addr + 32'h60);
        end
        ifc.imemREN = 1'b0;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        ifc.imemREN  = 1'b0;
        ifc.imemaddr = 32'h0;
        ifc.pcRST    = 1'b0;
        ifc.iflush   = 1'b0;
        ifc.iwait    = 1'b0;
        step();
        step();
        chk("rst_ihit", {31'h0, ifc.ihit}, 32'h0);
        chk("rst_load", ifc.imemload, 32'h0);
        chk("rst_iren", {31'h0, ifc.iREN}, 32'h0);
        chk("rst_iaddr", ifc.iaddr, 32'h0);
        chkCounts("rst");
        rst = 1'b0;
        step();

        // Cold miss, then the second word of the same block hits at once.
        fetch(32'h040, 1'b0);
        fetch(32'h044, 1'b1);
        chkCounts("cold");

        // Three tags in set 0: third evicts way 0, next miss evicts way 1.
        fetch(32'h440, 1'b0);
        fetch(32'h840, 1'b0);
        fetch(32'h440, 1'b1);
        fetch(32'h040, 1'b0);
        fetch(32'h840, 1'b1);
        fetch(32'h440, 1'b0);
        fetch(32'h040, 1'b1);
        chkCounts("assoc");

        // Stretched fill: 3 wait cycles per word, address moved mid-fill.
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = 32'h108;
        ifc.iwait    = 1'b1;
        #1;
        chk("stall_miss", {31'h0, ifc.ihit}, 32'h0);
        step();
        expMiss++;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) ifc.imemaddr = 32'h200;
            ifc.iwait = (i % 4 != 3);
            #1;
            chk("stall_iren", {31'h0, ifc.iREN}, 32'h1);
            chk("stall_iaddr", ifc.iaddr, 32'h108 + 32'(4 * (i / 4)));
            step();
        end
        ifc.iwait = 1'b0;
        chk("stall_commit", {31'h0, ifc.iREN}, 32'h0);
        step();
        ifc.imemaddr = 32'h108;
        #1;
        chk("stall_hit0", {31'h0, ifc.ihit}, 32'h1);
        chk("stall_load0", ifc.imemload, 32'h168);
        ifc.imemaddr = 32'h10C;
        #1;
        chk("stall_hit1", {31'h0, ifc.ihit}, 32'h1);
        chk("stall_load1", ifc.imemload, 32'h16C);
        ifc.imemREN = 1'b0;
        #1;

        // Abort in the second fill cycle, then the same address misses again.
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = 32'h110;
        step();
        expMiss++;
        chk("abort_fill1", {31'h0, ifc.iREN}, 32'h1);
        step();
        ifc.pcRST = 1'b1;
        #1;
        chk("abort_fill2", {31'h0, ifc.iREN}, 32'h1);
        step();
        ifc.pcRST = 1'b0;
        #1;
        chk("abort_iren", {31'h0, ifc.iREN}, 32'h0);
        chk("abort_nohit", {31'h0, ifc.ihit}, 32'h0);
        fetch(32'h110, 1'b0);
        chkCounts("abort");

        // Flush: every resident block misses afterwards.
        ifc.iflush = 1'b1;
        step();
        ifc.iflush = 1'b0;
        expHits = 0;
        expMiss = 0;
        #1;
        chkCounts("flush");
        ifc.imemREN = 1'b1;
        foreach (ifc.imemaddr[i]) begin end
        ifc.imemaddr = 32'h040;
        #1;
        chk("flush_040", {31'h0, ifc.ihit}, 32'h0);
        ifc.imemaddr = 32'h440;
        #1;
        chk("flush_440", {31'h0, ifc.ihit}, 32'h0);
        ifc.imemaddr = 32'h108;
        #1;
        chk("flush_108", {31'h0, ifc.ihit}, 32'h0);
        ifc.imemaddr = 32'h110;
        #1;
        chk("flush_110", {31'h0, ifc.ihit}, 32'h0);

        // Flush while in COMMIT: the line must not be installed.
        ifc.imemaddr = 32'h040;
        step();
        step();
        step();
        chk("fc_commit", {31'h0, ifc.iREN}, 32'h0);
        ifc.iflush = 1'b1;
        step();
        ifc.iflush = 1'b0;
        #1;
        chk("fc_nohit", {31'h0, ifc.ihit}, 32'h0);
        chkCounts("fc");
        ifc.imemREN = 1'b0;
        #1;

        // Asynchronous reset in the middle of a fill.
        fetch(32'h148, 1'b0);
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = 32'h040;
        step();
        expMiss++;
        chk("rmf_iren_pre", {31'h0, ifc.iREN}, 32'h1);
        chkCounts("rmf_pre");
        #2;
        rst = 1'b1;
        #1;
        expHits = 0;
        expMiss = 0;
        chk("rmf_iren", {31'h0, ifc.iREN}, 32'h0);
        chk("rmf_iaddr", ifc.iaddr, 32'h0);
        chk("rmf_ihit", {31'h0, ifc.ihit}, 32'h0);
        chkCounts("rmf");
        ifc.imemREN = 1'b0;
        step();
        rst = 1'b0;
        step();
        fetch(32'h148, 1'b0);
        chkCounts("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache. Successor to the direct-mapped, one-word-block icache.
- Sits between the datapath fetch port and the memory controller's instruction channel.
- Adds configurable sets, ways and words per block, multi-word block fill, per-set round-robin replacement, whole-cache flush, and fill abort.

Parameters:
- SETS, 8, number of sets; power of two, 2..64.
- WAYS, 2, associativity; one of 1, 2, 4.
- BLKWORDS, 2, 32-bit words per block; power of two, 1..8.
- CPUID, 0, index of this cache's slot on the shared controller vectors.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- imemREN  in  1  fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- pcRST  in  1  fetch abort; kills any in-flight fill.
- iflush  in  1  invalidate entire cache.
- ihit  out  1  lookup hit, combinational.
- imemload  out  32  hit data, combinational; 0 on miss.
- iREN  out  1  memory read request for the current fill word.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; data valid when iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  32  fetch hit counter (see Optional Feature).
- miss_count  out  32  fetch miss counter (see Optional Feature).

Behaviour:
- Address split, with OB = log2(BLKWORDS) and IB = log2(SETS):
  - [1:0] byte offset.
  - [OB+1:2] word offset.
  - [IB+OB+1:OB+2] set index.
  - Remaining upper bits are the tag; width TW = 30-IB-OB.
- Storage per set/way: valid bit, TW-bit tag, BLKWORDS data words. Per set: log2(WAYS)-bit victim pointer (absent when WAYS=1).
- Lookup:
  - ihit = imemREN & !pcRST & !iflush & (state==IDLE) & (some way valid with matching tag in the indexed set).
  - imemload = matching way's word at the word offset when ihit, else 0.
  - Never two matching valid ways; fills only install after a confirmed miss.
- FSM with states IDLE, FILL, COMMIT:
  - IDLE: on imemREN & !pcRST & !iflush & miss, latch tag, index and set base address, clear word counter wc, go to FILL. Otherwise stay in IDLE.
  - FILL:
    - Drive iREN=1 and iaddr={latched tag, index, wc, 2'b00}.
    - While iwait=1, hold.
    - While iwait=0, capture iload into fill buffer[wc]. If wc==BLKWORDS-1 go to COMMIT, else wc++.
    - Words are fetched in order 0..BLKWORDS-1.
  - COMMIT:
    - Choose the victim: lowest-numbered invalid way, else the set's victim pointer.
    - Write buffer, tag, valid=1 into that way.
    - If the victim pointer was used, increment it modulo WAYS.
    - Go to IDLE.
  - iREN=0 and iaddr=0 in IDLE and COMMIT.
- Latency with iwait permanently 0:
  - Miss detected cycle 0.
  - FILL cycles 1..BLKWORDS.
  - COMMIT cycle BLKWORDS+1.
  - ihit=1 in cycle BLKWORDS+2.
  - Hits are 0-cycle (same cycle as request).
- Abort: pcRST=1 in FILL → next state IDLE. Nothing installed, buffer discarded, iREN drops next cycle.
- Flush: iflush=1 clears all valid bits at the next edge, in any state.
  - In FILL or COMMIT it also aborts to IDLE with no install; flush wins over COMMIT in the same cycle.
  - Victim pointers are unchanged.
- imemaddr changing mid-fill does not redirect the fill. Fill completes to the latched address; the new address is looked up after returning to IDLE.
- Reset (RST=1, async):
  - state=IDLE, wc=0.
  - All valid bits, tags, data and victim pointers = 0.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
  - Reset mid-fill discards the fill.

Optional Feature:
- Macro ICACHE_ASSOC_STATS_EN.
- Defined:
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE→FILL transition.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by reset and by iflush.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Cold miss, SETS=8, WAYS=2, BLKWORDS=2: imemREN=1, imemaddr=0x00000040, iwait=0, iload returns 0xA0 then 0xA4.
  - iaddr=0x40 then 0x44 in cycles 1-2.
  - ihit=1 with imemload=0xA0 in cycle 4.
  - Then imemaddr=0x44 → immediate ihit, imemload=0xA4.
- Associativity/replacement: fill 0x040, 0x440, 0x840 (same set 0x40>>3 index), then re-fetch.
  - 0x840 evicts way 0 (0x040).
  - Fetch 0x440 hits; fetch 0x040 misses.
- iwait stretch: iwait=1 for 3 cycles per word.
  - iREN and iaddr held stable.
  - Fill takes 8 cycles of FILL.
  - Data installed correctly.
- Abort: pcRST=1 in the second FILL cycle.
  - iREN=0 next cycle.
  - Re-fetch of the same address misses again (miss_count increments twice with stats).
- Flush: after filling 4 blocks, pulse iflush.
  - All 4 addresses miss afterwards.
  - Flush during COMMIT leaves the line uninstalled.
- Reset mid-fill: assert RST asynchronously while iREN=1.
  - iREN=0, ihit=0, counters=0 immediately.
  - First fetch after release misses.
